// File: rtl/cpu_pkg.sv
//==============================================================================
// Module      : cpu_pkg
// Description : Shared constants, instruction field layout and fetch state
//               encoding for the 16-bit RISC core.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int INSTR_W_DEF = 16;

    // Instruction field positions: opcode | rs | rt | rd/imm
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RS_MSB     = 11;
    localparam int RS_LSB     = 8;
    localparam int RT_MSB     = 7;
    localparam int RT_LSB     = 4;
    localparam int RD_MSB     = 3;
    localparam int RD_LSB     = 0;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_JMP   = 4'b1001;

    localparam logic [15:0] HALT_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [3:0] get_opcode(input logic [15:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_counter.sv
//==============================================================================
// Module      : program_counter
// Description : Program counter register with async reset, target load,
//               wrap-around increment and hold.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module program_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] r_pc;

    // Load beats increment; the add wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (load_en) begin
            r_pc <= load_addr;
        end else if (inc_en) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: owns the PC, reads the combinational
//               instruction memory and feeds decode through the IF/ID register.
//               Optional HALT detection is enabled with macro FETCH_HALT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    output logic               halted
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_load;
    logic               w_is_halt;
    logic               w_capture;
    logic               w_pc_inc;
    logic               w_valid_nxt;

    program_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_en   (redirect_valid),
        .load_addr (redirect_addr),
        .inc_en    (w_pc_inc),
        .pc        (w_pc)
    );

    assign w_load = !r_if_valid || id_ready;

`ifdef FETCH_HALT_EN
    assign w_is_halt = (imem_instr == INSTR_W'(HALT_INSTR));
`else
    assign w_is_halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_pc_inc    = 1'b0;
        w_valid_nxt = r_if_valid;
        case (r_state)
            ST_RUN: begin
                if (w_load) begin
                    if (w_is_halt) begin
                        // The HALT word is swallowed and the PC parks on it.
                        w_state_nxt = ST_HALT;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_capture   = 1'b1;
                        w_pc_inc    = 1'b1;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_valid_nxt = 1'b0;
            end
        endcase
        // Redirect drops the in-flight instruction even on a transfer cycle.
        if (redirect_valid) begin
            w_state_nxt = ST_RUN;
            w_capture   = 1'b0;
            w_pc_inc    = 1'b0;
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_if_valid <= w_valid_nxt;
            if (w_capture) begin
                r_if_instr <= imem_instr;
                r_if_pc    <= w_pc;
            end
        end
    end

    assign imem_addr = w_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

`ifdef FETCH_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit RISC core. It owns the program counter and drives the read address of the combinational `instruction_memory`. It registers the returned instruction into the IF/ID pipeline register and hands it to decode with a valid/ready handshake. It accepts a single-cycle redirect (branch/jump/restart) from execute, which flushes the pipeline register.

## Interface
Parameters:
- `ADDR_W`, 4: program-counter and instruction-memory address width.
- `INSTR_W`, 16: instruction width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  ADDR_W  read address to instruction memory; always equals `pc`.
- `imem_instr`  in  INSTR_W  instruction returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  one-cycle pulse: load `redirect_addr` into `pc`.
- `redirect_addr`  in  ADDR_W  redirect target.
- `if_valid`  out  1  IF/ID register holds a valid instruction.
- `if_instr`  out  INSTR_W  registered instruction (opcode[15:12], rs[11:8], rt[7:4], rd/imm[3:0]).
- `if_pc`  out  ADDR_W  address that `if_instr` was fetched from.
- `id_ready`  in  1  decode accepts `if_instr` this cycle.
- `halted`  out  1  fetch stopped on HALT; constant 0 when `FETCH_HALT_EN` is undefined.

## Operation
- Reset values: `pc`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0, state RUN. Reset takes effect immediately, including mid-transfer.
- Transfer: occurs when `if_valid && id_ready`.
- Load condition (`load`): `!if_valid || id_ready`. This allows full throughput of one instruction per cycle.
- On `load` in RUN:
  - `if_instr` <= `imem_instr`
  - `if_pc` <= `pc`
  - `if_valid` <= 1
  - `pc` <= `pc`+1, modulo 2^ADDR_W, so 15 wraps to 0.
- Stall: `if_valid && !id_ready` holds `pc`, `if_instr`, `if_pc` and `if_valid` unchanged.
- Redirect has the highest priority and overrides stall, load and HALT:
  - `pc` <= `redirect_addr`
  - `if_valid` <= 0, so the in-flight instruction is dropped even if decode asserted `id_ready` that cycle.
  - state <= RUN, `halted` <= 0.
- States: RUN and HALT. HALT exists only with `FETCH_HALT_EN`.
  - RUN -> HALT: on `load` with `imem_instr`==HALT_INSTR (16'h0000), without redirect.
  - HALT -> RUN: on `redirect_valid` or `rst` only.
- HALT entry actions: the HALT word is not forwarded; `if_valid` <= 0; `pc` holds at the HALT address; `halted` <= 1.
- In HALT: `if_valid` stays 0; `imem_addr` stays at the HALT address.

## Timing
- Redirect at edge N: `imem_addr`=`redirect_addr` after N; target instruction valid at `if_*` after N+1. Redirect-to-output latency is 1 cycle, with a 1-cycle bubble.
- `imem_addr` follows `pc` combinationally. `imem_instr` is sampled in the same cycle with no wait state.
- All outputs are registered, except `imem_addr`, which is a direct copy of the `pc` register.
- `if_*` are stable throughout a stall.
- `if_valid` never depends combinationally on `id_ready`.

## Configuration
- Macro `FETCH_HALT_EN`:
  - Defined: HALT state and HALT_INSTR detection as above; `halted` is functional.
  - Undefined: 16'h0000 is forwarded as an ordinary instruction; fetch never stops; `halted` is tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - ADDR_W and INSTR_W defaults.
  - Instruction field positions.
  - Opcode constants (LOAD=4'b0110, STORE=4'b0111, etc.).
  - HALT_INSTR=16'h0000.
  - Fetch state encoding.
- Sub-module `program_counter`: ADDR_W register with async reset, increment-with-wrap, hold and load-target controls.
- `fetch_unit` contains the state logic and the IF/ID register.

## Test plan
- Reset, `id_ready`=1, memory words 0..7 non-zero -> `if_pc`=0,1,2,… on consecutive cycles; `if_instr` matches memory; first valid one cycle after reset release.
- Hold `id_ready`=0 for 3 cycles while `if_pc`=2 -> `if_pc`/`if_instr` unchanged and `pc` stays 3; release -> next `if_pc`=3 with no skip or duplicate.
- Pulse `redirect_valid` with `redirect_addr`=5 while `if_valid`=1 and `id_ready`=0 -> next cycle `if_valid`=0; following cycle `if_pc`=5.
- All 16 words non-zero, free-run -> `if_pc` sequence 14,15,0,1 (wrap).
- `FETCH_HALT_EN` defined, word 8 = 16'h0000 -> `if_pc`=7 is last valid; `halted`=1 and `imem_addr`=8 held; redirect to 0 -> `halted`=0, `if_pc`=0 next.
- Assert `rst` mid-stall with `if_valid`=1 -> immediately `if_valid`=0 and `imem_addr`=0, without waiting for a clock edge.
